// File: rtl/dmem_arbiter.sv
// Data memory port arbiter between the CPU datapath and a DMA master.
// Build option DMEM_ARB_RR_EN: round-robin on conflict instead of CPU priority with starvation guard.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    output logic [7:0] cpu_din,
    output logic       cpu_stall,
    input  logic       dbg_is_brk,
    input  logic       dma_req,
    input  logic       dma_wr,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_wdata,
    input  logic       dma_lock,
    output logic       dma_gnt,
    output logic       dma_ack,
    output logic [7:0] dma_rdata,
    input  logic [7:0] mem_din,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_dout,
    output logic       mem_wr,
    output logic       mem_rd
);

    logic cpu_req;
    logic grant_dma;
    logic grant_cpu;
    logic lock_q;
    logic dma_ack_q;

    assign cpu_req = cpu_rd | cpu_wr;

`ifdef DMEM_ARB_RR_EN
    logic last_q;
    logic conflict;

    // last_q records the previous conflict winner (0 = CPU, 1 = DMA)
    assign conflict  = cpu_req & dma_req & ~lock_q & ~dbg_is_brk;
    assign grant_dma = dma_req & ~dbg_is_brk & (~cpu_req | lock_q | ~last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (conflict) begin
            last_q <= grant_dma;
        end
    end
`else
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt;
    logic       starved;

    assign starved   = (starve_cnt == LIMIT);
    assign grant_dma = dma_req & ~dbg_is_brk & (~cpu_req | lock_q | starved);

    // Counter freezes during a breakpoint so the debugger does not trigger a forced DMA slot
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (~dma_req | grant_dma) begin
            starve_cnt <= 3'd0;
        end else if (~dbg_is_brk & ~starved) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`endif

    assign grant_cpu = cpu_req & ~grant_dma;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            dma_ack_q <= 1'b0;
        end else begin
            lock_q    <= grant_dma & dma_lock & dma_req & ~dbg_is_brk;
            dma_ack_q <= grant_dma;
        end
    end

    always_comb begin
        mem_addr = 8'h00;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        mem_rd   = 1'b0;
        if (grant_dma) begin
            mem_addr = dma_addr;
            mem_dout = dma_wdata;
            mem_wr   = dma_wr;
            mem_rd   = ~dma_wr;
        end else if (grant_cpu) begin
            mem_addr = cpu_addr;
            mem_dout = cpu_dout;
            mem_wr   = cpu_wr;
            mem_rd   = cpu_rd;
        end
    end

    assign cpu_stall = cpu_req & ~grant_cpu;
    assign dma_gnt   = grant_dma;
    assign dma_ack   = dma_ack_q;
    assign cpu_din   = mem_din;
    assign dma_rdata = mem_din;

endmodule
